rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Inverse of the main control decoder: accepts instruction class plus fields and emits a 32-bit RV32I machine word.
- Each word carries an instruction-memory byte address, so a testbench or loader can fill imem for the single-cycle core.
- Covers the same class set the core decodes: lw, sw, R-type, beq, I-type ALU, jal.
- One registered output stage with valid/ready on both sides; range checking on immediates.

Parameters:
- DEPTH, 64: maximum number of words emitted before the block reports full.
- BASE_ADDR, 32'h0000_0000: byte address assigned to the first emitted word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block can accept the input this cycle.
- kind  in  3  0=lw, 1=sw, 2=R, 3=beq, 4=I-ALU, 5=jal, 6/7 illegal.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  used by R and I-ALU only; lw/sw force 010, beq forces 000.
- f7b5  in  1  funct7 bit 5 for R-type (sub/sra); all other funct7 bits are 0.
- imm  in  21  signed immediate, two's complement.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer takes the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  byte address of out_instr.
- count  out  $clog2(DEPTH+1)  number of words accepted since reset.
- full  out  1  count == DEPTH.
- err  out  1  sticky; set by any rejected input.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, full=0, err=0.
- Reset mid-operation discards any pending output word.
- in_ready = !full && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Latency: one cycle. A word accepted in cycle N appears with out_valid=1 in cycle N+1 and holds stable until out_valid && out_ready.
- Accepting in the same cycle the register drains gives back-to-back throughput of 1 word/cycle.
- Encodings:
  - lw: opcode 0000011, I-format.
  - sw: opcode 0100011, S-format.
  - R: opcode 0110011, funct7 = {0, f7b5, 00000}.
  - beq: opcode 1100011, B-format.
  - I-ALU: opcode 0010011, imm[11:0].
  - jal: opcode 1101111, J-format.
  - Fields not used by a format are ignored.
- Legality checks on accept (illegal kind or immediate):
  - I/S: imm[20:11] must all equal imm[11].
  - B: imm[20:12] must equal imm[12], and imm[0] must be 0.
  - J: imm[0] must be 0; all 21 bits are usable.
  - kind 6/7 is illegal.
- Illegal input: still consumed (handshake completes), err is set to 1, no output word, count and address unchanged.
- Legal accept: count increments. The word's address = BASE_ADDR + 4*(count before increment). full asserts when count reaches DEPTH; in_ready is then 0 permanently until reset.
- Words already in the output register still drain after full asserts.
- No combinational path from in_valid to out_valid; in_ready depends combinationally on out_ready only.

Test Plan:
- lw x5,8(x2) (kind=0, rd=5, rs1=2, imm=8), out_ready=1 -> next cycle out_instr=0x00812283, out_addr=0x0, count=1.
- Back-to-back stream: add x3,x1,x2 (kind=2, funct3=0, f7b5=0); sw x6,12(x2); beq x1,x2,-4; jal x1,8 -> words 0x002081B3, 0x00612623, 0xFE208EE3, 0x008000EF at addrs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Backpressure: out_ready=0 with two valid inputs -> first word held stable; in_ready=0 for the second until out_ready=1; no loss or duplication.
- Errors:
  - beq imm=3 -> err=1, no output, count unchanged.
  - I-ALU imm=2048 -> rejected.
  - kind=7 -> rejected.
  - A following legal input still encodes normally, and err stays 1.
- DEPTH=2 -> after two legal accepts full=1, in_ready=0, a third input is stalled; reset returns count=0, full=0, err=0, out_addr=BASE_ADDR.
- Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and the pending word is dropped.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// RV32I encoder: class + fields -> 32-bit machine word with its imem byte address; one registered stage.
// Latency 1 cycle; in_ready = !full && (!out_valid || out_ready), so the word holds while out_ready is low.
module rv_instr_encoder #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   kind,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [2:0]                   funct3,
  input  logic                         f7b5,
  input  logic [20:0]                  imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_addr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] K_LW   = 3'd0;
  localparam logic [2:0] K_SW   = 3'd1;
  localparam logic [2:0] K_R    = 3'd2;
  localparam logic [2:0] K_BEQ  = 3'd3;
  localparam logic [2:0] K_IALU = 3'd4;
  localparam logic [2:0] K_JAL  = 3'd5;

  logic        accept;
  logic        legal;
  logic [31:0] enc;
  logic        fits12;
  logic        fits13;
  logic [31:0] word_off;

  assign full     = (count == DEPTH_C);
  assign in_ready = !full && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign word_off = 32'(count) << 2;

  // Sign-extension checks: upper bits must replicate the top bit of the immediate field.
  assign fits12 = (&imm[20:11]) || !(|imm[20:11]);
  assign fits13 = (&imm[20:12]) || !(|imm[20:12]);

  always_comb begin
    legal = 1'b0;
    enc   = 32'h0;
    case (kind)
      K_LW: begin
        legal = fits12;
        enc   = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      end
      K_SW: begin
        legal = fits12;
        enc   = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      end
      K_R: begin
        legal = 1'b1;
        enc   = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
      end
      K_BEQ: begin
        legal = fits13 && !imm[0];
        enc   = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      end
      K_IALU: begin
        legal = fits12;
        enc   = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      K_JAL: begin
        legal = !imm[0];
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      default: begin
        legal = 1'b0;
        enc   = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_addr  <= BASE_ADDR;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_instr <= enc;
        out_addr  <= BASE_ADDR + word_off;
        count     <= count + CW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Rejected inputs complete the handshake but only leave a sticky flag behind.
      if (accept && !legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed vector table, hand sequences for stall/reset/full, then
// randomized traffic scored against an arithmetic encoding model and a word queue.
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic        in_ready, out_valid, full, err;
  logic [2:0]  kind, funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        f7b5;
  logic signed [20:0] imm;
  logic [31:0] out_instr, out_addr;
  logic [6:0]  count;

  logic        reset2, in_valid2, out_ready2;
  logic        in_ready2, out_valid2, full2, err2;
  logic [31:0] out_instr2, out_addr2;
  logic [1:0]  count2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rv_instr_encoder #(.DEPTH(64), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .kind(kind),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .f7b5(f7b5), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .full(full), .err(err)
  );

  rv_instr_encoder #(.DEPTH(2), .BASE_ADDR(32'h100)) dut2 (
    .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_ready(in_ready2), .kind(kind),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .f7b5(f7b5), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_addr(out_addr2),
    .count(count2), .full(full2), .err(err2)
  );

  typedef struct {
    bit          rst;
    logic [2:0]  k;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic        f7;
    int          im;
    bit          lg;
    logic [31:0] w;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(bit r, int k, int d, int s1, int s2, int f3, int f7, int im, bit lg,
                              logic [31:0] w);
    vec_t v;
    v.rst = r; v.k = 3'(k); v.d = 5'(d); v.s1 = 5'(s1); v.s2 = 5'(s2);
    v.f3 = 3'(f3); v.f7 = 1'(f7); v.im = im; v.lg = lg; v.w = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the field layouts by shifting and masking integers.
  function automatic logic [31:0] ref_enc(input logic [31:0] k, input logic [31:0] d,
      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] f3, input logic [31:0] f7,
      input int im, output bit ok);
    logic [31:0] u;
    u = im;
    ok = 1'b1;
    ref_enc = 32'h0;
    case (k)
      32'd0, 32'd4: begin
        ok = (im >= -2048) && (im <= 2047);
        ref_enc = ((u & 32'hfff) << 20) | (s1 << 15) | ((k == 32'd0 ? 32'd2 : f3) << 12)
                | (d << 7) | (k == 32'd0 ? 32'h03 : 32'h13);
      end
      32'd1: begin
        ok = (im >= -2048) && (im <= 2047);
        ref_enc = (((u >> 5) & 32'h7f) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                | ((u & 32'h1f) << 7) | 32'h23;
      end
      32'd2: ref_enc = (f7 << 30) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
      32'd3: begin
        ok = (im >= -4096) && (im <= 4095) && ((u & 32'd1) == 32'd0);
        ref_enc = (((u >> 12) & 32'd1) << 31) | (((u >> 5) & 32'h3f) << 25) | (s2 << 20)
                | (s1 << 15) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'd1) << 7) | 32'h63;
      end
      32'd5: begin
        ok = (u & 32'd1) == 32'd0;
        ref_enc = (((u >> 20) & 32'd1) << 31) | (((u >> 1) & 32'h3ff) << 21)
                | (((u >> 11) & 32'd1) << 20) | (((u >> 12) & 32'hff) << 12) | (d << 7) | 32'h6f;
      end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    kind = v.k; rd = v.d; rs1 = v.s1; rs2 = v.s2; funct3 = v.f3; f7b5 = v.f7; imm = 21'(v.im);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [63:0] sb[$];
  int          m_count;
  bit          m_err;
  int          bl[10];

  initial begin
    int   nlegal;
    bit   exp_err, ok, exp_rdy;
    logic [31:0] w;
    logic [63:0] e;
    int   v;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    reset2 = 1'b1; in_valid2 = 1'b0; out_ready2 = 1'b1;
    kind = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; f7b5 = 0; imm = 0;
    bl = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, 3};

    vt[0]  = mk(1, 0, 5, 2, 0, 0, 0, 8,     1, 32'h00812283);
    vt[1]  = mk(1, 2, 3, 1, 2, 0, 0, 0,     1, 32'h002081B3);
    vt[2]  = mk(0, 1, 0, 2, 6, 0, 0, 12,    1, 32'h00612623);
    vt[3]  = mk(0, 3, 0, 1, 2, 0, 0, -4,    1, 32'hFE208EE3);
    vt[4]  = mk(0, 5, 1, 0, 0, 0, 0, 8,     1, 32'h008000EF);
    vt[5]  = mk(0, 3, 0, 1, 2, 0, 0, 3,     0, 32'h0);
    vt[6]  = mk(0, 4, 1, 0, 0, 0, 0, 2048,  0, 32'h0);
    vt[7]  = mk(0, 7, 1, 1, 1, 0, 0, 0,     0, 32'h0);
    vt[8]  = mk(0, 4, 1, 0, 0, 0, 0, -1,    1, 32'hFFF00093);
    vt[9]  = mk(0, 2, 3, 1, 2, 0, 1, 0,     1, 32'h402081B3);
    vt[10] = mk(0, 5, 0, 0, 0, 0, 0, -2,    1, 32'hFFFFF06F);
    vt[11] = mk(0, 0, 1, 1, 0, 0, 0, -2049, 0, 32'h0);
    vt[12] = mk(0, 1, 0, 2, 6, 0, 0, -2048, 1, 32'h80612023);
    vt[13] = mk(0, 3, 0, 1, 2, 0, 0, 4094,  1, 32'h7E208FE3);
    vt[14] = mk(0, 3, 0, 1, 2, 0, 0, 4096,  0, 32'h0);

    do_reset;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, one input per cycle with the consumer always ready.
    nlegal = 0; exp_err = 0;
    for (int i = 0; i < 15; i++) begin
      if (vt[i].rst) begin
        do_reset;
        nlegal = 0; exp_err = 0;
      end
      @(negedge clk);
      drive(vt[i]); in_valid = 1'b1; out_ready = 1'b1;
      #1 chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (vt[i].lg) begin
        chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("tbl%0d_instr", i), out_instr, vt[i].w);
        chk($sformatf("tbl%0d_addr", i), out_addr, 32'(nlegal * 4));
        nlegal++;
      end else begin
        exp_err = 1;
        chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'd0);
      end
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(nlegal));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(exp_err));
    end
    @(negedge clk); in_valid = 1'b0;

    // Backpressure: first word must hold, second must stall, then both arrive in order.
    do_reset;
    out_ready = 1'b0; drive(vt[1]); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk("bp_first_instr", out_instr, 32'h002081B3);
    @(negedge clk); drive(vt[2]);
    #1 chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_hold_instr", out_instr, 32'h002081B3);
    chk("bp_hold_addr", out_addr, 32'h0);
    chk("bp_hold_count", 32'(count), 32'd1);
    @(negedge clk); out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_second_instr", out_instr, 32'h00612623);
    chk("bp_second_addr", out_addr, 32'h4);
    chk("bp_second_count", 32'(count), 32'd2);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_no_dup_count", 32'(count), 32'd2);

    // Reset while a word is stalled in the output register drops it.
    @(negedge clk); out_ready = 1'b0; drive(vt[0]); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rmid_pending", 32'(out_valid), 32'd1);
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("rmid_valid", 32'(out_valid), 32'd0);
    chk("rmid_count", 32'(count), 32'd0);
    chk("rmid_addr", out_addr, 32'h0);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rmid_dropped", 32'(out_valid), 32'd0);

    // DEPTH=2 instance at base 0x100: error, two words, then a permanent stall until reset.
    @(negedge clk); reset2 = 1'b0; out_ready2 = 1'b1; drive(vt[7]); in_valid2 = 1'b1;
    @(posedge clk); #1;
    chk("d2_err", 32'(err2), 32'd1);
    @(negedge clk); drive(vt[0]);
    @(posedge clk); #1;
    chk("d2_addr0", out_addr2, 32'h100);
    chk("d2_instr0", out_instr2, 32'h00812283);
    @(negedge clk); drive(vt[1]);
    @(posedge clk); #1;
    chk("d2_addr1", out_addr2, 32'h104);
    chk("d2_count2", 32'(count2), 32'd2);
    chk("d2_full", 32'(full2), 32'd1);
    chk("d2_in_ready_full", 32'(in_ready2), 32'd0);
    @(negedge clk); drive(vt[4]);
    @(posedge clk); #1;
    chk("d2_third_count", 32'(count2), 32'd2);
    chk("d2_third_valid", 32'(out_valid2), 32'd0);
    chk("d2_still_stalled", 32'(in_ready2), 32'd0);
    @(negedge clk); in_valid2 = 1'b0; reset2 = 1'b1;
    @(posedge clk); #1;
    chk("d2_rst_count", 32'(count2), 32'd0);
    chk("d2_rst_full", 32'(full2), 32'd0);
    chk("d2_rst_err", 32'(err2), 32'd0);
    chk("d2_rst_addr", out_addr2, 32'h100);
    chk("d2_rst_in_ready", 32'(in_ready2), 32'd1);

    // Randomized traffic against the model; each batch starts from reset and may reach full.
    for (int b = 0; b < 4; b++) begin
      do_reset;
      sb.delete(); m_count = 0; m_err = 0;
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        kind = 3'($urandom_range(0, 7)); rd = 5'($urandom); rs1 = 5'($urandom);
        rs2 = 5'($urandom); funct3 = 3'($urandom); f7b5 = 1'($urandom);
        case ($urandom_range(0, 3))
          0: v = int'(21'($urandom));
          1: v = $urandom_range(0, 40) - 20;
          2: v = bl[$urandom_range(0, 9)];
          default: v = $urandom_range(0, 4095) - 2048;
        endcase
        imm = 21'(v);
        #1;
        exp_rdy = (m_count < 64) && (sb.size() == 0 || out_ready);
        chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("rnd_out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
          chk("rnd_instr", out_instr, sb[0][63:32]);
          chk("rnd_addr", out_addr, sb[0][31:0]);
        end
        chk("rnd_count", 32'(count), 32'(m_count));
        chk("rnd_full", 32'(full), 32'(m_count == 64));
        chk("rnd_err", 32'(err), 32'(m_err));
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (in_valid && exp_rdy) begin
          w = ref_enc(32'(kind), 32'(rd), 32'(rs1), 32'(rs2), 32'(funct3), 32'(f7b5),
                      int'(imm), ok);
          if (ok) begin
            e = {w, 32'(m_count * 4)};
            sb.push_back(e);
            m_count++;
          end else begin
            m_err = 1;
          end
        end
      end
    end

    @(negedge clk); in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
